seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning bits per scanned word (range 4..64).
REQ-002 The block SHALL have parameter PAT_LEN, default 3, meaning pattern length in bits (range 2..8, PAT_LEN <= WIDTH).
REQ-003 The block SHALL have parameter PATTERN, default 3'b101, meaning target pattern, PAT_LEN bits, first-received bit in MSB.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match_count width.
REQ-005 clock  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-007 start  input  1  request to scan data_in; accepted only when busy=0.
REQ-008 data_in  input  WIDTH  word to scan, sampled only on the accepting edge.
REQ-009 busy  output  1  high from the accepting edge until done deasserts.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 match_count  output  CNT_W  number of overlapping pattern matches in the last scanned word.
REQ-012 first_pos  output  8  stream index of the bit completing the first match; present only with SEQ_SCAN_FIRST_POS_EN.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE: IDLE->SHIFT on start; SHIFT->DONE after WIDTH SHIFT cycles; DONE->IDLE unconditionally.
REQ-014 On the accepting edge the block SHALL capture data_in, clear the history register, bit counter, match_count and first_pos, and set busy.
REQ-015 In SHIFT the block SHALL present one bit per cycle, MSB first; stream index i (0..WIDTH-1) corresponds to data_in[WIDTH-1-i].
REQ-016 Each presented bit SHALL shift into a PAT_LEN-bit history; a match SHALL be counted when at least PAT_LEN bits of the current word have been seen and the history equals PATTERN.
REQ-017 Matching SHALL be overlapping: the matched bits are retained and reused (e.g. 10101 with 101 yields 2 matches).
REQ-018 History SHALL NOT carry across words; bits from a previous word never contribute to a match.
REQ-019 match_count SHALL saturate at 2^CNT_W-1.
REQ-020 done SHALL be high for exactly one cycle, in state DONE, WIDTH+1 rising edges after the accepting edge; busy SHALL be high during SHIFT and DONE.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT be queued; start in the DONE cycle is ignored.
REQ-022 Changes on data_in after the accepting edge SHALL NOT affect the scan.
REQ-023 match_count and first_pos SHALL hold their values from done until the next accepting edge.

Reset
REQ-024 Reset SHALL force state IDLE, busy=0, done=0, match_count=0, first_pos=8'hFF, and clear the history and bit counter.
REQ-025 Reset asserted mid-SHIFT SHALL abort the scan with no done pulse; a start seen in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 With macro SEQ_SCAN_FIRST_POS_EN defined, port first_pos and its logic SHALL exist: it is set to index i on the first match of a word and is 8'hFF if the word has no match.
REQ-027 Without SEQ_SCAN_FIRST_POS_EN, the first_pos port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Defaults, start with data_in=16'hA000 -> done 17 edges later, match_count=1, first_pos=2.
REQ-029 data_in=16'hAAAA -> match_count=7, first_pos=2; data_in=16'h0000 and 16'hFFFF -> match_count=0, first_pos=8'hFF.
REQ-030 Scan 16'h0005, then scan 16'h8000 -> second match_count=0, proving history is not carried across words.
REQ-031 Pulse start again 5 cycles into a scan with different data -> ignored, one done only, results from the first word.
REQ-032 Assert reset 8 cycles into a scan -> no done, busy=0, match_count=0, first_pos=8'hFF next cycle; a new start then scans normally.
REQ-033 Build without SEQ_SCAN_FIRST_POS_EN, run REQ-028/029 stimulus -> identical done timing and match_count.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Scans one WIDTH-bit word, MSB first and one bit per clock, and counts
// overlapping occurrences of PATTERN in the bit stream.
//
// Optional feature macro: SEQ_SCAN_FIRST_POS_EN adds the first_pos output,
// which gives the stream index of the bit that completes the first match.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   scan request, accepted only while busy=0
//   data_in      in   word to scan, sampled on the accepting edge only
//   busy         out  high from the accepting edge until done deasserts
//   done         out  one-cycle pulse, results valid
//   match_count  out  overlapping matches in the last word (saturating)
//   first_pos    out  index of the first match, 8'hFF if none (optional)
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | presenting bits; one extra cycle when bit_cnt==WIDTH ends the scan
// DONE  | done pulse, results held
module seq_scan_ctrl #(
  parameter int                 WIDTH   = 16,
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
`ifdef SEQ_SCAN_FIRST_POS_EN
  output logic [7:0]       first_pos,
`endif
  output logic [CNT_W-1:0] match_count
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [PAT_LEN-1:0] r_hist;
  logic [BW-1:0]      r_bit_cnt;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_match_count;
`ifdef SEQ_SCAN_FIRST_POS_EN
  logic [7:0]         r_first_pos;
`endif

  logic               w_bit;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic               w_hit;
  logic               w_cnt_max;

  // r_data shifts left, so the MSB is always the bit being presented.
  assign w_bit      = r_data[WIDTH-1];
  assign w_hist_nxt = {r_hist[PAT_LEN-2:0], w_bit};
  // r_bit_cnt is the index of the bit now being presented; a match needs
  // PAT_LEN bits of this word, i.e. index >= PAT_LEN-1.
  assign w_hit      = (r_bit_cnt >= BW'(PAT_LEN - 1)) && (w_hist_nxt == PATTERN);
  assign w_cnt_max  = &r_match_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_data        <= '0;
      r_hist        <= '0;
      r_bit_cnt     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match_count <= '0;
`ifdef SEQ_SCAN_FIRST_POS_EN
      r_first_pos   <= 8'hFF;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state       <= SHIFT;
            r_data        <= data_in;
            r_hist        <= '0;
            r_bit_cnt     <= '0;
            r_busy        <= 1'b1;
            r_match_count <= '0;
`ifdef SEQ_SCAN_FIRST_POS_EN
            r_first_pos   <= 8'hFF;
`endif
          end
        end
        SHIFT: begin
          if (r_bit_cnt == BW'(WIDTH)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_data    <= {r_data[WIDTH-2:0], 1'b0};
            r_hist    <= w_hist_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_hit) begin
              if (!w_cnt_max) r_match_count <= r_match_count + 1'b1;
`ifdef SEQ_SCAN_FIRST_POS_EN
              // count is still zero only before the first match of the word
              if (r_match_count == '0) r_first_pos <= 8'(r_bit_cnt);
`endif
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign match_count = r_match_count;
`ifdef SEQ_SCAN_FIRST_POS_EN
  assign first_pos   = r_first_pos;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic        busy, done, busy_s, done_s;
  logic [7:0]  match_count;
  logic [1:0]  match_count_s;
`ifdef SEQ_SCAN_FIRST_POS_EN
  logic [7:0]  first_pos, first_pos_s;
`endif

  always #5 clock = ~clock;

  seq_scan_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy), .done(done),
`ifdef SEQ_SCAN_FIRST_POS_EN
    .first_pos(first_pos),
`endif
    .match_count(match_count)
  );

  // narrow counter instance to exercise saturation
  seq_scan_ctrl #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy_s), .done(done_s),
`ifdef SEQ_SCAN_FIRST_POS_EN
    .first_pos(first_pos_s),
`endif
    .match_count(match_count_s)
  );

  typedef struct {
    logic [15:0] data;
    int          cnt;
    int          fp;
  } vec_t;

  typedef struct {
    int cnt;
    int fp;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // independent reference: slide a 3-bit window over the stream
  function automatic void model(input logic [15:0] d, output int c, output int fp);
    logic [2:0] win;
    c  = 0;
    fp = 255;
    for (int i = 2; i < 16; i++) begin
      win = {d[17-i], d[16-i], d[15-i]};
      if (win == 3'b101) begin
        c++;
        if (fp == 255) fp = i;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("match_count", match_count, e.cnt);
        check("sat_count", match_count_s, (e.cnt > 3) ? 3 : e.cnt);
        check("sat_done_align", done_s, 1);
`ifdef SEQ_SCAN_FIRST_POS_EN
        check("first_pos", first_pos, e.fp);
`endif
      end
    end
  end

  task automatic run_scan(input logic [15:0] d, input int ec, input int efp);
    int n;
    bit seen;
    exp_t e;
    @(negedge clock);
    data_in = d;
    start   = 1'b1;
    e.cnt = ec;
    e.fp  = efp;
    sb.push_back(e);
    @(posedge clock); #1;
    check("busy_on_accept", busy, 1);
    @(negedge clock);
    start   = 1'b0;
    data_in = ~d;          // must not disturb the scan in flight
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) seen = 1;
    end
    check("done_latency", n, 17);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clock); #1;
      if (done) ok = 1;
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   c, fp, d0;
    bit   ok;
    logic [15:0] r;

    vecs[0] = '{16'hA000, 1, 2};
    vecs[1] = '{16'hAAAA, 7, 2};
    vecs[2] = '{16'h0000, 0, 255};
    vecs[3] = '{16'hFFFF, 0, 255};
    vecs[4] = '{16'h5555, 7, 3};
    vecs[5] = '{16'h0005, 1, 15};
    vecs[6] = '{16'h8000, 0, 255};   // follows 0005: no carried history

    reset = 1'b1;
    start = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
`ifdef SEQ_SCAN_FIRST_POS_EN
    check("rst_first_pos", first_pos, 255);
`endif
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_scan(vecs[i].data, vecs[i].cnt, vecs[i].fp);

    for (int i = 0; i < 4; i++) begin
      r = 16'($urandom);
      model(r, c, fp);
      run_scan(r, c, fp);
    end

    // start pulse 5 cycles into a scan is dropped
    d0 = n_done;
    @(negedge clock);
    data_in = 16'hA000;
    start = 1'b1;
    sb.push_back('{1, 2});
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    data_in = 16'hAAAA;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    check("busy_ignore_start", busy, 0);
    check("dones_ignore_start", n_done - d0, 1);

    // start presented during the done cycle is dropped
    d0 = n_done;
    @(negedge clock);
    data_in = 16'h0000;
    start = 1'b1;
    sb.push_back('{0, 255});
    @(negedge clock);
    start = 1'b0;
    wait_done(ok);
    check("done_seen_for_done_start", ok, 1);
    data_in = 16'hAAAA;
    start = 1'b1;
    @(posedge clock); #1;
    check("busy_start_in_done", busy, 0);
    start = 1'b0;
    repeat (30) @(negedge clock);
    check("dones_start_in_done", n_done - d0, 1);

    // reset 8 cycles into a scan aborts it
    d0 = n_done;
    @(negedge clock);
    data_in = 16'hAAAA;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", match_count, 0);
`ifdef SEQ_SCAN_FIRST_POS_EN
    check("abort_first_pos", first_pos, 255);
`endif
    // start coincident with reset is ignored
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    check("busy_start_with_reset", busy, 0);
    repeat (25) @(negedge clock);
    check("dones_after_abort", n_done - d0, 0);

    run_scan(16'hA000, 1, 2);
    run_scan(16'hAAAA, 7, 2);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
